// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, key-expansion FSM states and the GF(2^8) xtime helper.
package aes_pkg;
  localparam int AES_NK = 4;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  typedef enum logic {ST_IDLE, ST_EMIT} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (FIPS-197 table lookup).
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  // Row-major table; byte n occupies bits [8n +: 8] of the ascending vector.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_s = SBOX[{i_a, 3'b000} +: 8];
endmodule

// File: rtl/aes128_key_expand_seq.sv
// aes128_key_expand_seq: iterative AES-128 key expansion, one round key per accepted handshake.
module aes128_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int IDX_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [127:0]     i_key,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [127:0]     o_rk,
  output logic [IDX_W-1:0] o_rk_idx,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic             o_done
);
  state_e           r_state;
  logic [127:0]     r_key;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_rcon;
  logic             r_rk_valid, r_done, r_key_ready;
  logic [31:0]      w_rot, w_sub, w_t, w_w4, w_w5, w_w6, w_w7;
  logic             w_accept, w_last, w_rcon_hold;
  assign w_rot = {r_key[23:0], r_key[31:24]};
  for (genvar g = 0; g < AES_NK; g++) begin : g_sbox
    aes_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
  end
  assign w_t         = w_sub ^ {r_rcon, 24'h0};
  assign w_w4        = r_key[127:96] ^ w_t;
  assign w_w5        = r_key[95:64] ^ w_w4;
  assign w_w6        = r_key[63:32] ^ w_w5;
  assign w_w7        = r_key[31:0] ^ w_w6;
  assign w_accept    = r_rk_valid & i_rk_ready;
  assign w_last      = r_idx == IDX_W'(NUM_ROUNDS);
  assign w_rcon_hold = r_idx == IDX_W'(NUM_ROUNDS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_idx       <= '0;
      r_rcon      <= RCON_INIT;
      r_rk_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_key_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (i_key_valid) begin
          r_key       <= i_key;
          r_idx       <= '0;
          r_rcon      <= RCON_INIT;
          r_rk_valid  <= 1'b1;
          r_key_ready <= 1'b0;
          r_state     <= ST_EMIT;
        end
      end else if (w_accept) begin
        if (w_last) begin
          r_rk_valid  <= 1'b0;
          r_done      <= 1'b1;
          r_key_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_key  <= {w_w4, w_w5, w_w6, w_w7};
          r_idx  <= r_idx + 1'b1;
          r_rcon <= w_rcon_hold ? r_rcon : xtime(r_rcon);
        end
      end
    end
  end
  assign o_key_ready = r_key_ready;
  assign o_rk        = r_key;
  assign o_rk_idx    = r_idx;
  assign o_rk_valid  = r_rk_valid;
  assign o_done      = r_done;
endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// tb_aes128_key_expand_seq: directed checks of the key-expansion engine against FIPS-197 vectors.
module tb_aes128_key_expand_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;
  int           total = 0;
  int           bad = 0;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] fips [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes128_key_expand_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_key_valid(key_valid),
    .o_key_ready(key_ready), .o_rk(rk), .o_rk_idx(rk_idx), .o_rk_valid(rk_valid),
    .i_rk_ready(rk_ready), .o_done(done)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int  e;
    bit  fin;
    rst_n = 1'b0; key = '0; key_valid = 1'b0; rk_ready = 1'b0;
    #12;
    chk("rst_rk", rk, 128'h0);
    chk("rst_idx", 128'(rk_idx), 128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_key_ready", 128'(key_ready), 128'h1);
    rst_n = 1'b1;
    tick;
    // FIPS key, consumer always ready
    key = FIPS_KEY; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_valid = 1'b0;
    chk("fips_key_ready_busy", 128'(key_ready), 128'h0);
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("fips_rk%0d", i), rk, fips[i]);
      chk($sformatf("fips_idx%0d", i), 128'(rk_idx), 128'(i));
      chk($sformatf("fips_valid%0d", i), 128'(rk_valid), 128'h1);
      chk($sformatf("fips_nodone%0d", i), 128'(done), 128'h0);
      tick;
    end
    chk("fips_done", 128'(done), 128'h1);
    chk("fips_valid_low", 128'(rk_valid), 128'h0);
    chk("fips_key_ready_done", 128'(key_ready), 128'h1);
    // key B offered in the o_done cycle
    key = '0; key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    chk("b2b_done_low", 128'(done), 128'h0);
    chk("b2b_rk0", rk, 128'h0);
    chk("b2b_idx0", 128'(rk_idx), 128'h0);
    chk("b2b_valid", 128'(rk_valid), 128'h1);
    tick;
    chk("zero_rk1", rk, ZERO_RK1);
    for (int i = 1; i < 10; i++) tick;
    chk("zero_idx10", 128'(rk_idx), 128'd10);
    chk("zero_rk10", rk, ZERO_RK10);
    tick;
    chk("zero_done", 128'(done), 128'h1);
    rk_ready = 1'b0;
    tick;
    chk("zero_done_pulse", 128'(done), 128'h0);
    chk("zero_ready_no_effect", 128'(rk_valid), 128'h0);
    // throttled consumer, stray keys offered while busy
    key = FIPS_KEY; key_valid = 1'b1;
    tick;
    e = 0; fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      chk("thr_rk", rk, fips[e]);
      chk("thr_idx", 128'(rk_idx), 128'(e));
      chk("thr_valid", 128'(rk_valid), 128'h1);
      rk_ready = (c % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      key = '1;
      key_valid = 1'($urandom_range(0, 1));
      tick;
      if (rk_ready) begin
        if (e == 10) fin = 1'b1;
        else e++;
      end
    end
    key_valid = 1'b0;
    chk("thr_finished", 128'(fin), 128'h1);
    chk("thr_done", 128'(done), 128'h1);
    // reset in the middle of an expansion
    key = FIPS_KEY; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("abort_idx5", 128'(rk_idx), 128'd5);
    chk("abort_rk5", rk, fips[5]);
    rst_n = 1'b0;
    #1;
    chk("abort_rk", rk, 128'h0);
    chk("abort_idx", 128'(rk_idx), 128'h0);
    chk("abort_valid", 128'(rk_valid), 128'h0);
    chk("abort_done", 128'(done), 128'h0);
    chk("abort_key_ready", 128'(key_ready), 128'h1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("abort_no_done", 128'(done), 128'h0);
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("restart_rk%0d", i), rk, fips[i]);
      chk($sformatf("restart_idx%0d", i), 128'(rk_idx), 128'(i));
      chk($sformatf("restart_nodone%0d", i), 128'(done), 128'h0);
      tick;
    end
    chk("restart_done", 128'(done), 128'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
